regfile_write_arbiter: RTL and testbench

Shares the single write port of the CPU's 32×32 register file between two writeback sources: requester 0 (ALU result) and requester 1 (memory load data). It grants at most one write per cycle using round-robin priority and registers the chosen write into a one-stage write buffer that drives the register file. It also provides forwarding flags for the in-flight write, because the register file does not see that data until the next clock edge. Writes to register 0 are accepted and discarded, so r0 stays zero.

---
 rtl/regfile_write_arbiter.sv | 75 +++++++
 tb/tb_regfile_write_arbiter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - round-robin arbiter for the register file write port with a one-stage write buffer and forwarding flags
module regfile_write_arbiter #(
    parameter int AW = 5,
    parameter int DW = 32
) (
    input  logic          CLK,
    input  logic          reset,
    input  logic          stall,
    input  logic          v0,
    input  logic [AW-1:0] rd0,
    input  logic [DW-1:0] d0,
    output logic          ready0,
    input  logic          v1,
    input  logic [AW-1:0] rd1,
    input  logic [DW-1:0] d1,
    output logic          ready1,
    output logic          wr_en,
    output logic [AW-1:0] wr_rd,
    output logic [DW-1:0] wr_data,
    input  logic [AW-1:0] q_rs,
    input  logic [AW-1:0] q_rt,
    output logic          fwd1,
    output logic          fwd2,
    output logic          last
);

    logic          grant0;
    logic          grant1;
    logic          contested;
    logic [AW-1:0] sel_rd;
    logic [DW-1:0] sel_data;

    // Grant decision: a lone requester always wins, a contest goes to the one that did not win the previous contest.
    // Reset gating keeps pending requests from being accepted while reset is held.
    always_comb begin
        contested = v0 & v1;
        grant0    = reset & ~stall & v0 & (~v1 | last);
        grant1    = reset & ~stall & v1 & (~v0 | ~last);
        ready0    = grant0;
        ready1    = grant1;
        sel_rd    = grant1 ? rd1 : rd0;
        sel_data  = grant1 ? d1  : d0;
    end

    // Round-robin pointer: only contested grants move it, so an idle competitor does not lose its turn.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            last <= 1'b1;
        end else if (contested && (grant0 || grant1)) begin
            last <= grant1;
        end
    end

    // Write buffer: writes to r0 are accepted but never enabled; address/data hold when idle.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            wr_en   <= 1'b0;
            wr_rd   <= '0;
            wr_data <= '0;
        end else if (grant0 || grant1) begin
            wr_en   <= (sel_rd != '0);
            wr_rd   <= sel_rd;
            wr_data <= sel_data;
        end else begin
            wr_en   <= 1'b0;
        end
    end

    // Forwarding: the buffered write is not yet in the register file, so matching reads must take wr_data.
    always_comb begin
        fwd1 = wr_en & (wr_rd == q_rs) & (q_rs != '0);
        fwd2 = wr_en & (wr_rd == q_rt) & (q_rt != '0);
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - scoreboard bench for regfile_write_arbiter
module tb_regfile_write_arbiter;

    localparam int AW = 5;
    localparam int DW = 32;

    logic          CLK = 1'b0;
    logic          reset;
    logic          stall;
    logic          v0, v1;
    logic [AW-1:0] rd0, rd1;
    logic [DW-1:0] d0, d1;
    logic          ready0, ready1;
    logic          wr_en;
    logic [AW-1:0] wr_rd;
    logic [DW-1:0] wr_data;
    logic [AW-1:0] q_rs, q_rt;
    logic          fwd1, fwd2;
    logic          last;

    typedef struct {
        logic          en;
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } wr_t;

    wr_t           sb[$];
    logic          m_last;
    logic [AW-1:0] m_rd;
    logic [DW-1:0] m_data;
    logic          g_seen0, g_seen1;
    int            checks = 0;
    int            errors = 0;

    regfile_write_arbiter #(.AW(AW), .DW(DW)) dut (
        .CLK(CLK), .reset(reset), .stall(stall),
        .v0(v0), .rd0(rd0), .d0(d0), .ready0(ready0),
        .v1(v1), .rd1(rd1), .d1(d1), .ready1(ready1),
        .wr_en(wr_en), .wr_rd(wr_rd), .wr_data(wr_data),
        .q_rs(q_rs), .q_rt(q_rt), .fwd1(fwd1), .fwd2(fwd2), .last(last)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic model_init();
        wr_t w;
        sb.delete();
        m_last = 1'b1;
        m_rd   = '0;
        m_data = '0;
        w.en = 1'b0; w.rd = '0; w.data = '0;
        sb.push_back(w);
    endtask

    // one clock: sample and compare mid-cycle, push next buffer state, return just after the rising edge
    task automatic cycle();
        logic mg0, mg1;
        wr_t  exp, nxt;
        @(negedge CLK);
        mg0 = !stall && v0 && (!v1 || m_last);
        mg1 = !stall && v1 && (!v0 || !m_last);
        check("ready0", ready0, mg0);
        check("ready1", ready1, mg1);
        check("ready_onehot", ready0 & ready1, 0);
        check("last", last, m_last);
        g_seen0 = ready0;
        g_seen1 = ready1;
        if (sb.size() > 0) begin
            exp = sb.pop_front();
            check("wr_en", wr_en, exp.en);
            check("wr_rd", wr_rd, exp.rd);
            check("wr_data", wr_data, exp.data);
            check("fwd1", fwd1, exp.en && exp.rd == q_rs && q_rs != 0);
            check("fwd2", fwd2, exp.en && exp.rd == q_rt && q_rt != 0);
        end
        if (mg0 || mg1) begin
            m_rd   = mg1 ? rd1 : rd0;
            m_data = mg1 ? d1 : d0;
            nxt.en = (m_rd != 0);
            if (v0 && v1) m_last = mg1;
        end else begin
            nxt.en = 1'b0;
        end
        nxt.rd   = m_rd;
        nxt.data = m_data;
        sb.push_back(nxt);
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        check("rst_wr_en", wr_en, 0);
        check("rst_wr_rd", wr_rd, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_last", last, 1);
        check("rst_ready0", ready0, 0);
        check("rst_ready1", ready1, 0);
        @(posedge CLK);
        #1;
        reset = 1'b1;
        model_init();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout got=running expected=finished");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; stall = 1'b0;
        v0 = 0; v1 = 0; rd0 = 0; rd1 = 0; d0 = 0; d1 = 0;
        q_rs = 0; q_rt = 0;
        @(posedge CLK); #1;
        do_reset();

        // single write from requester 0
        v0 = 1; rd0 = 5; d0 = 32'hDEADBEEF;
        cycle();
        check("t1_ready0", g_seen0, 1);
        v0 = 0;
        cycle();
        cycle();

        // stall with both valid, then release: requester 0 wins first contest
        stall = 1; v0 = 1; rd0 = 3; d0 = 32'h11111111; v1 = 1; rd1 = 4; d1 = 32'h22222222;
        repeat (3) cycle();
        stall = 0;
        cycle();
        check("stall_release_r0", g_seen0, 1);
        v0 = 0; v1 = 0;
        cycle();

        // contest: alternating grants starting with requester 0
        do_reset();
        v0 = 1; rd0 = 10; d0 = 32'hAAAA0000; v1 = 1; rd1 = 11; d1 = 32'hBBBB0000;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("order", g_seen1, i % 2);
            if (g_seen0) d0 = d0 + 1;
            if (g_seen1) d1 = d1 + 1;
        end
        v0 = 0; v1 = 0;
        cycle();

        // write to r0 is discarded, no forward on q_rs=0
        v1 = 1; rd1 = 0; d1 = 32'h1234; q_rs = 0;
        cycle();
        check("r0_ready1", g_seen1, 1);
        v1 = 0;
        cycle();
        cycle();

        // forwarding on rd 7
        v0 = 1; rd0 = 7; d0 = 32'hA5A5A5A5; q_rs = 7; q_rt = 8;
        cycle();
        v0 = 0;
        cycle();
        cycle();
        q_rs = 0; q_rt = 0;

        // reset while a write is in flight
        v0 = 1; rd0 = 9; d0 = 32'hCAFEF00D;
        cycle();
        check("pre_rst_wr_en", wr_en, 1);
        do_reset();
        v0 = 0;
        cycle();
        cycle();

        // random traffic with stable pending requests
        for (int i = 0; i < 200; i++) begin
            if (!v0 || g_seen0) begin v0 = $urandom_range(0, 1); rd0 = AW'($urandom); d0 = $urandom; end
            if (!v1 || g_seen1) begin v1 = $urandom_range(0, 1); rd1 = AW'($urandom); d1 = $urandom; end
            stall = ($urandom_range(0, 4) == 0);
            q_rs  = AW'($urandom);
            q_rt  = AW'($urandom_range(0, 3));
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
